// File: rtl/fde_pkg.sv
// Shared definitions for the FDE CPU decode/execute boundary.
// Holds the default datapath widths, the bubble opcode and the index of
// the hard-wired zero register.
package fde_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int OP_W_DEF   = 4;

    // Opcode presented on the output while the slot holds a bubble.
    localparam int NOP_OPCODE = 0;

    // Register 0 always reads as zero and is never tracked as pending.
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard.
// A bit is set when an instruction that writes that register issues, and
// cleared by write-back of that register or by a flush (which clears all).
// Three lookup ports (two sources and one destination) return busy flags.
// Register 0 is never tracked.
//
// Ports:
//   i_clk, i_reset          clock, async active-low reset
//   set_en, set_idx         mark a register pending (issue)
//   clr_en, clr_idx         clear a pending register (write-back)
//   flush                   clear every pending bit
//   src1, src2, dest        lookup addresses
//   src1_busy, src2_busy,
//   dest_busy               pending status of the looked-up registers
import fde_pkg::*;

module regfile_scoreboard #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic              flush,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic [ADDR_W-1:0] dest,
    output logic              src1_busy,
    output logic              src2_busy,
    output logic              dest_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0] pending;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            if (clr_en && clr_idx != ZERO_IDX) begin
                pending[clr_idx] <= 1'b0;
            end
            // Issued after the clear so a same-cycle set on the same index wins.
            if (set_en && set_idx != ZERO_IDX) begin
                pending[set_idx] <= 1'b1;
            end
        end
    end

    assign src1_busy = (src1 != ZERO_IDX) && pending[src1];
    assign src2_busy = (src2 != ZERO_IDX) && pending[src2];
    assign dest_busy = (dest != ZERO_IDX) && pending[dest];

endmodule

// File: rtl/regfile_pipe.sv
// Register file plus decode-to-execute pipeline register.
// Two read ports with optional write-back bypass feed a registered output
// slot; a pending scoreboard stalls RAW and WAW hazards at issue.
//
// Ports:
//   i_clk, i_reset                      clock, async active-low reset
//   i_valid, i_opcode, i_destadd,
//   i_dest_we, i_read_reg1, i_read_reg2 decode slot
//   i_stall                             hold the output slot
//   i_flush                             kill slots, clear scoreboard
//   i_write_en, i_write_reg,
//   i_write_data                        write-back port
//   o_valid, o_opcode, o_destadd,
//   o_dest_we, o_read_data1/2           registered execute slot
//   o_hazard                            decode instruction cannot issue
import fde_pkg::*;

module regfile_pipe #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [OP_W-1:0]   i_opcode,
    input  logic [ADDR_W-1:0] i_destadd,
    input  logic              i_dest_we,
    input  logic [ADDR_W-1:0] i_read_reg1,
    input  logic [ADDR_W-1:0] i_read_reg2,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_write_en,
    input  logic [ADDR_W-1:0] i_write_reg,
    input  logic [DATA_W-1:0] i_write_data,
    output logic              o_valid,
    output logic [OP_W-1:0]   o_opcode,
    output logic [ADDR_W-1:0] o_destadd,
    output logic              o_dest_we,
    output logic [DATA_W-1:0] o_read_data1,
    output logic [DATA_W-1:0] o_read_data2,
    output logic              o_hazard
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
    localparam logic [OP_W-1:0]   NOP_OP   = OP_W'(NOP_OPCODE);

    logic [DATA_W-1:0] mem [DEPTH];

    logic wb_commit;
    logic fwd1, fwd2;
    logic src1_busy, src2_busy, dest_busy;
    logic src1_ok, src2_ok;
    logic accept;
    logic set_pending;
    logic [DATA_W-1:0] rd1, rd2;

    assign wb_commit = i_write_en && (i_write_reg != ZERO_IDX);

    // Forwarding only ever matches non-zero registers because wb_commit
    // excludes register 0.
    assign fwd1 = (BYPASS != 0) && wb_commit && (i_write_reg == i_read_reg1);
    assign fwd2 = (BYPASS != 0) && wb_commit && (i_write_reg == i_read_reg2);

    assign rd1 = fwd1 ? i_write_data : mem[i_read_reg1];
    assign rd2 = fwd2 ? i_write_data : mem[i_read_reg2];

    regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .set_en    (set_pending),
        .set_idx   (i_destadd),
        .clr_en    (wb_commit),
        .clr_idx   (i_write_reg),
        .flush     (i_flush),
        .src1      (i_read_reg1),
        .src2      (i_read_reg2),
        .dest      (i_destadd),
        .src1_busy (src1_busy),
        .src2_busy (src2_busy),
        .dest_busy (dest_busy)
    );

    // A same-cycle write-back resolves a source only when it is forwarded;
    // it never resolves the destination check.
    assign src1_ok = !src1_busy || fwd1;
    assign src2_ok = !src2_busy || fwd2;

    assign o_hazard = i_valid && (!src1_ok || !src2_ok || (i_dest_we && dest_busy));

    assign accept      = i_valid && !o_hazard && !i_stall && !i_flush;
    assign set_pending = accept && i_dest_we;

    // Write-back commits regardless of stall or flush.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
        end else if (wb_commit) begin
            mem[i_write_reg] <= i_write_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_valid      <= 1'b0;
            o_opcode     <= NOP_OP;
            o_destadd    <= '0;
            o_dest_we    <= 1'b0;
            o_read_data1 <= '0;
            o_read_data2 <= '0;
        end else if (i_flush || (!i_stall && !accept)) begin
            o_valid      <= 1'b0;
            o_opcode     <= NOP_OP;
            o_destadd    <= '0;
            o_dest_we    <= 1'b0;
            o_read_data1 <= '0;
            o_read_data2 <= '0;
        end else if (accept) begin
            o_valid      <= 1'b1;
            o_opcode     <= i_opcode;
            o_destadd    <= i_destadd;
            o_dest_we    <= i_dest_we;
            o_read_data1 <= rd1;
            o_read_data2 <= rd2;
        end
    end

endmodule

// File: tb/tb_regfile_pipe.sv
module tb_regfile_pipe;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int OW    = 4;
    localparam int BYP   = 1;
    localparam int DEPTH = 1 << AW;

    logic          i_clk;
    logic          i_reset;
    logic          i_valid;
    logic [OW-1:0] i_opcode;
    logic [AW-1:0] i_destadd;
    logic          i_dest_we;
    logic [AW-1:0] i_read_reg1;
    logic [AW-1:0] i_read_reg2;
    logic          i_stall;
    logic          i_flush;
    logic          i_write_en;
    logic [AW-1:0] i_write_reg;
    logic [DW-1:0] i_write_data;
    logic          o_valid;
    logic [OW-1:0] o_opcode;
    logic [AW-1:0] o_destadd;
    logic          o_dest_we;
    logic [DW-1:0] o_read_data1;
    logic [DW-1:0] o_read_data2;
    logic          o_hazard;

    int n_checks = 0;
    int n_errors = 0;

    regfile_pipe #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW), .BYPASS(BYP)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_opcode     (i_opcode),
        .i_destadd    (i_destadd),
        .i_dest_we    (i_dest_we),
        .i_read_reg1  (i_read_reg1),
        .i_read_reg2  (i_read_reg2),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .i_write_en   (i_write_en),
        .i_write_reg  (i_write_reg),
        .i_write_data (i_write_data),
        .o_valid      (o_valid),
        .o_opcode     (o_opcode),
        .o_destadd    (o_destadd),
        .o_dest_we    (o_dest_we),
        .o_read_data1 (o_read_data1),
        .o_read_data2 (o_read_data2),
        .o_hazard     (o_hazard)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural model: register contents, pending set, expected output slot.
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_pend [DEPTH];
    logic          m_valid;
    logic [OW-1:0] m_op;
    logic [AW-1:0] m_dest;
    logic          m_dwe;
    logic [DW-1:0] m_d1, m_d2;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = DW'(i);
            m_pend[i] = 1'b0;
        end
        m_valid = 0; m_op = 0; m_dest = 0; m_dwe = 0; m_d1 = 0; m_d2 = 0;
    endtask

    function automatic bit wb_to(input logic [AW-1:0] r);
        return i_write_en && i_write_reg == r && r != 0;
    endfunction

    function automatic bit resolved(input logic [AW-1:0] s);
        return (s == 0) || !m_pend[s] || (BYP == 1 && wb_to(s));
    endfunction

    function automatic bit model_hazard();
        return i_valid && (!resolved(i_read_reg1) || !resolved(i_read_reg2) ||
               (i_dest_we && i_destadd != 0 && m_pend[i_destadd]));
    endfunction

    function automatic logic [DW-1:0] operand(input logic [AW-1:0] s);
        if (s == 0) return '0;
        if (BYP == 1 && wb_to(s)) return i_write_data;
        return m_regs[s];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("o_valid",      32'(o_valid),      32'(m_valid));
        check("o_opcode",     32'(o_opcode),     32'(m_op));
        check("o_destadd",    32'(o_destadd),    32'(m_dest));
        check("o_dest_we",    32'(o_dest_we),    32'(m_dwe));
        check("o_read_data1", 32'(o_read_data1), 32'(m_d1));
        check("o_read_data2", 32'(o_read_data2), 32'(m_d2));
        check("o_hazard",     32'(o_hazard),     32'(model_hazard()));
    endtask

    // One cycle: compare at the falling edge, advance the model across the
    // rising edge. exp_haz >= 0 also pins the hazard to a literal value.
    task automatic step(input int exp_haz);
        bit haz, acc;
        logic [DW-1:0] rd1, rd2;
        @(negedge i_clk);
        compare_all();
        if (exp_haz >= 0) check("hazard_literal", 32'(o_hazard), 32'(exp_haz));
        haz = model_hazard();
        acc = i_valid && !haz && !i_stall && !i_flush;
        rd1 = operand(i_read_reg1);
        rd2 = operand(i_read_reg2);
        @(posedge i_clk);
        if (i_reset) begin
            if (i_write_en && i_write_reg != 0) m_regs[i_write_reg] = i_write_data;
            if (i_flush) begin
                for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
            end else begin
                if (i_write_en && i_write_reg != 0) m_pend[i_write_reg] = 1'b0;
                if (acc && i_dest_we && i_destadd != 0) m_pend[i_destadd] = 1'b1;
            end
            if (i_flush || (!i_stall && !acc)) begin
                m_valid = 0; m_op = 0; m_dest = 0; m_dwe = 0; m_d1 = 0; m_d2 = 0;
            end else if (acc) begin
                m_valid = 1; m_op = i_opcode; m_dest = i_destadd; m_dwe = i_dest_we;
                m_d1 = rd1; m_d2 = rd2;
            end
        end
        #1;
    endtask

    task automatic idle();
        i_valid = 0; i_opcode = 0; i_destadd = 0; i_dest_we = 0;
        i_read_reg1 = 0; i_read_reg2 = 0; i_stall = 0; i_flush = 0;
        i_write_en = 0; i_write_reg = 0; i_write_data = 0;
    endtask

    task automatic issue(input logic [OW-1:0] op, input logic [AW-1:0] dest,
                         input logic we, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        i_valid = 1; i_opcode = op; i_destadd = dest; i_dest_we = we;
        i_read_reg1 = r1; i_read_reg2 = r2;
    endtask

    task automatic writeback(input logic en, input logic [AW-1:0] r, input logic [DW-1:0] d);
        i_write_en = en; i_write_reg = r; i_write_data = d;
    endtask

    initial begin
        idle();
        i_reset = 0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_valid", 32'(o_valid), 32'h0);
        check("reset_data1", 32'(o_read_data1), 32'h0);
        i_reset = 1;
        step(0);

        // Reset contents readable
        issue(4'h2, 4'd0, 1'b0, 4'd5, 4'd15);
        step(0);
        check("rst_read1", 32'(o_read_data1), 32'h05);
        check("rst_read2", 32'(o_read_data2), 32'h0F);
        check("rst_valid", 32'(o_valid), 32'h1);

        // Register 0 protection
        idle(); writeback(1'b1, 4'd0, 8'hAA);
        step(-1);
        idle(); issue(4'h1, 4'd0, 1'b1, 4'd0, 4'd0);
        step(0);
        check("r0_read", 32'(o_read_data1), 32'h00);
        step(0);

        // RAW hazard then bypass
        issue(4'h3, 4'd3, 1'b1, 4'd1, 4'd2);
        step(0);
        issue(4'h4, 4'd5, 1'b1, 4'd3, 4'd0);
        step(1);
        check("raw_bubble", 32'(o_valid), 32'h0);
        step(1);
        writeback(1'b1, 4'd3, 8'h5C);
        step(0);
        check("raw_bypass", 32'(o_read_data1), 32'h5C);
        check("raw_op", 32'(o_opcode), 32'h4);
        writeback(1'b0, 4'd0, 8'h00);

        // WAW: destination check ignores a same-cycle write-back
        issue(4'h5, 4'd4, 1'b1, 4'd0, 4'd0);
        step(0);
        issue(4'h6, 4'd4, 1'b1, 4'd0, 4'd0);
        step(1);
        step(1);
        writeback(1'b1, 4'd4, 8'h33);
        step(1);
        writeback(1'b0, 4'd0, 8'h00);
        step(0);
        check("waw_accept", 32'(o_opcode), 32'h6);
        check("waw_dest", 32'(o_destadd), 32'h4);

        // Stall hold with write-back underneath
        issue(4'h7, 4'd0, 1'b0, 4'd1, 4'd2);
        step(0);
        idle(); i_stall = 1; writeback(1'b1, 4'd2, 8'h11);
        step(-1);
        writeback(1'b0, 4'd0, 8'h00);
        step(-1);
        step(-1);
        check("stall_hold_op", 32'(o_opcode), 32'h7);
        check("stall_hold_d2", 32'(o_read_data2), 32'h02);
        i_stall = 0;
        issue(4'h8, 4'd2, 1'b1, 4'd2, 4'd0);
        step(0);
        check("stall_wb", 32'(o_read_data1), 32'h11);

        // Flush with same-cycle write-back
        issue(4'h9, 4'd6, 1'b1, 4'd0, 4'd0);
        step(0);
        check("pre_flush_valid", 32'(o_valid), 32'h1);
        issue(4'hA, 4'd7, 1'b1, 4'd0, 4'd0);
        i_flush = 1; writeback(1'b1, 4'd6, 8'h99);
        step(-1);
        check("flush_valid", 32'(o_valid), 32'h0);
        i_flush = 0; writeback(1'b0, 4'd0, 8'h00);
        issue(4'hB, 4'd0, 1'b0, 4'd6, 4'd5);
        step(0);
        check("flush_r6", 32'(o_read_data1), 32'h99);
        check("flush_r5", 32'(o_read_data2), 32'h05);

        // Bypass to both ports
        issue(4'hC, 4'd8, 1'b1, 4'd0, 4'd0);
        step(0);
        issue(4'hD, 4'd0, 1'b0, 4'd8, 4'd8);
        step(1);
        writeback(1'b1, 4'd8, 8'h3C);
        step(0);
        check("both_d1", 32'(o_read_data1), 32'h3C);
        check("both_d2", 32'(o_read_data2), 32'h3C);
        writeback(1'b0, 4'd0, 8'h00);

        // Flush and stall together: flush wins
        issue(4'hE, 4'd0, 1'b0, 4'd1, 4'd0);
        step(0);
        idle(); i_stall = 1; i_flush = 1;
        step(-1);
        check("flush_over_stall", 32'(o_valid), 32'h0);
        idle();

        // Mid-operation reset
        issue(4'hF, 4'd9, 1'b1, 4'd1, 4'd1);
        step(0);
        i_reset = 0;
        model_reset();
        #1;
        check("midrst_valid", 32'(o_valid), 32'h0);
        idle();
        step(-1);
        i_reset = 1;
        issue(4'h1, 4'd9, 1'b1, 4'd9, 4'd3);
        step(0);
        check("midrst_r3", 32'(o_read_data2), 32'h03);
        idle();
        step(-1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_pipe.md
# regfile_pipe

Parametrised register file and decode-to-execute pipeline register for the FDE CPU. It provides two registered read ports with write-back bypass and a per-register pending scoreboard that raises a read-after-write or write-after-write hazard. Opcode, destination and valid are carried alongside the read data, and the stage supports stall and flush. It sits between instruction decode and the ALU/execute stage, and receives write-back from the final stage.

## Interface
- DATA_W, 8: register width
- ADDR_W, 4: register address width; depth = 2^ADDR_W
- OP_W, 4: opcode width
- BYPASS, 1: 1 forwards same-cycle write-back data to the read ports; 0 makes the reads see the pre-write array
- i_clk  in  1  clock; all state updates on the rising edge
- i_reset  in  1  reset; asynchronous, active-low
- i_valid  in  1  decode slot holds an instruction
- i_opcode  in  OP_W  decoded opcode
- i_destadd  in  ADDR_W  destination register
- i_dest_we  in  1  instruction will write i_destadd
- i_read_reg1, i_read_reg2  in  ADDR_W  source registers
- i_stall  in  1  execute stage cannot accept; hold outputs
- i_flush  in  1  kill the output slot and the input slot; clear the scoreboard
- i_write_en  in  1  write-back strobe
- i_write_reg  in  ADDR_W  write-back address
- i_write_data  in  DATA_W  write-back data
- o_valid  out  1  output slot valid
- o_opcode  out  OP_W  registered opcode
- o_destadd  out  ADDR_W  registered destination
- o_dest_we  out  1  registered write-enable intent
- o_read_data1, o_read_data2  out  DATA_W  registered operands
- o_hazard  out  1  combinational; the input instruction cannot issue this cycle

## Operation
- **Array reset:** register i resets to i mod 2^DATA_W, and register 0 resets to 0.
- **Register 0:** register 0 is read-only. Writes to it are ignored, and it is never pending.
- **Write-back:** if i_write_en and i_write_reg != 0, the array stores i_write_data and pending[i_write_reg] clears.
- **Source status:** a source s is resolved when s == 0, when pending[s] == 0, or when BYPASS = 1 and a write-back to s occurs this cycle.
- **Hazard:** o_hazard = i_valid & (source 1 unresolved | source 2 unresolved | (i_dest_we & i_destadd != 0 & pending[i_destadd])).
  - The destination check blocks write-after-write.
  - With BYPASS = 0, a same-cycle write-back does not resolve a source.
- **Accept:** accept = i_valid & ~o_hazard & ~i_stall & ~i_flush.
- **On accept:**
  - Outputs load the input fields and the read data, forwarded per BYPASS.
  - o_valid is set to 1.
  - If i_dest_we and i_destadd != 0, pending[i_destadd] is set.
  - A same-cycle set and clear on the same index leaves the bit set.
- **Bubble (~i_stall, not accept):** o_valid, o_opcode, o_destadd, o_dest_we and both data outputs go to 0.
- **Stall (i_stall, no flush):** all outputs hold. Write-back still commits and clears pending bits.
- **Flush:**
  - Highest priority: outputs go to a bubble and every pending bit clears.
  - A write-back in the same cycle still commits to the array.
  - Flush is asserted only when no instruction older than the output slot remains that depends on the scoreboard.

## Timing
- Every output resets to 0 while i_reset is low, and the pending vector resets to 0. Reset mid-operation discards the in-flight slot.
- The read-to-output latency is 1 cycle: the input is sampled at edge N and appears on the outputs after edge N.
- o_hazard is combinational from the inputs and the current pending/array state. It does not depend on i_stall.
- A stalled, hazarded instruction is re-evaluated each cycle. The issuer must hold the input fields stable until accept.
- A write-back to a pending source with BYPASS = 1 lets the consumer issue in that same cycle, with the forwarded value.
- Write-back to an address both sources use forwards to both ports.

## Structure
- Shared package fde_pkg holds:
  - DATA_W, ADDR_W and OP_W defaults
  - the bubble/NOP opcode constant (0)
  - the register-0 index constant
- Sub-module regfile_scoreboard:
  - Contains the 2^ADDR_W pending bits, with set, clear and flush logic.
  - Provides a 3-port lookup: src1, src2, dest.
  - Returns resolved/busy flags and is reused by later multi-issue work.
- Array, bypass multiplexers and output registers stay in regfile_pipe.

## Test plan
- **Reset, then read:** release reset; issue read_reg1=5, read_reg2=15 with valid -> after 1 edge, o_read_data1=0x05, o_read_data2=0x0F, o_valid=1.
- **Register 0 protection:** write reg 0 with 0xAA, then read reg 0 -> 0x00; pending[0] never set.
- **RAW hazard then bypass:** issue dest=3 with we -> the next instruction reading r3 sees o_hazard=1 and outputs bubble with o_valid=0. In the cycle write-back r3=0x5C arrives, o_hazard=0 and, after the edge, o_read_data1=0x5C. With BYPASS=0, issue happens one cycle later.
- **WAW block:** with r4 pending, issue a second instruction with dest=4 -> o_hazard=1 until write-back of r4, then accept.
- **Stall hold:** accept opcode 0x7, then hold i_stall=1 for 3 cycles while writing r2=0x11 -> outputs unchanged during the stall; the array holds 0x11; pending[2] clear.
- **Flush:** with r6 pending and o_valid=1, pulse i_flush -> o_valid=0 and all pending clear; a same-cycle write-back r6=0x99 later reads as 0x99; an instruction reading r6 issues without hazard.
